// File: rtl/bcd_pkg.sv
// bcd_pkg: shared FSM states, BCD digit width and the double-dabble digit adjust.
package bcd_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam int BCD_DIGIT_W = 4;

    function automatic logic [BCD_DIGIT_W-1:0] add3_if_ge5(input logic [BCD_DIGIT_W-1:0] digit);
        return (digit >= 4'd5) ? digit + 4'd3 : digit;
    endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// bcd_dabble_step: one combinational double-dabble iteration (adjust all digits, shift in one bit).
module bcd_dabble_step
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic [BCD_DIGIT_W*DIGITS-1:0] i_digits,
    input  logic                          i_in_bit,
    output logic [BCD_DIGIT_W*DIGITS-1:0] o_digits,
    output logic                          o_carry_out
);

    logic [BCD_DIGIT_W*DIGITS-1:0] w_adj;

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        assign w_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W] = add3_if_ge5(i_digits[g*BCD_DIGIT_W +: BCD_DIGIT_W]);
    end

    assign {o_carry_out, o_digits} = {w_adj, i_in_bit};

endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter, one double-dabble iteration per clock,
// valid/ready on both sides, optional signed input and overflow flag.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 12,
    parameter int DIGITS = 4,
    parameter int SIGNED = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BIN_W-1:0]              bin,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
    output logic                          neg,
    output logic                          overflow,
    output logic                          busy
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int BCD_W = BCD_DIGIT_W * DIGITS;

    state_t           r_state, w_next;
    logic [BIN_W-1:0] r_mag, w_mag;
    logic [BCD_W-1:0] r_digits, w_digits;
    logic [CNT_W-1:0] r_cnt;
    logic             r_neg, r_ovf;
    logic             w_neg, w_carry, w_accept, w_last;

    assign w_accept = in_valid && (r_state == IDLE);
    assign w_neg    = (SIGNED != 0) && bin[BIN_W-1];
    // -2^(BIN_W-1) negates to itself, which is the correct unsigned magnitude
    assign w_mag    = w_neg ? ~bin + 1'b1 : bin;
    assign w_last   = (r_cnt == CNT_W'(1));

    bcd_dabble_step #(.DIGITS(DIGITS)) u_step (
        .i_digits    (r_digits),
        .i_in_bit    (r_mag[BIN_W-1]),
        .o_digits    (w_digits),
        .o_carry_out (w_carry)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = in_valid  ? SHIFT : IDLE;
            SHIFT:   w_next = w_last    ? DONE  : SHIFT;
            DONE:    w_next = out_ready ? IDLE  : DONE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mag    <= '0;
            r_digits <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_mag    <= w_mag;
            r_digits <= '0;
            r_cnt    <= CNT_W'(BIN_W);
            r_neg    <= w_neg;
            r_ovf    <= 1'b0;
        end else if (r_state == SHIFT) begin
            r_mag    <= {r_mag[BIN_W-2:0], 1'b0};
            r_digits <= w_digits;
            r_cnt    <= r_cnt - 1'b1;
            r_ovf    <= r_ovf | w_carry;
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign bcd       = r_digits;
    assign neg       = r_neg;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: scoreboard bench over three configurations (default, DIGITS=3, SIGNED=1).
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] bin = '0;
    logic [2:0]  iv = '0, ordy = 3'b111;
    logic [2:0]  ir, ov, ng, of, bz;
    logic [15:0] bcd0, bcd2;
    logic [11:0] bcd1;

    always #5 clk = ~clk;

    bin2bcd_seq #(.BIN_W(12), .DIGITS(4), .SIGNED(0)) u_d0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .bin(bin),
        .out_valid(ov[0]), .out_ready(ordy[0]), .bcd(bcd0), .neg(ng[0]), .overflow(of[0]), .busy(bz[0]));
    bin2bcd_seq #(.BIN_W(12), .DIGITS(3), .SIGNED(0)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .bin(bin),
        .out_valid(ov[1]), .out_ready(ordy[1]), .bcd(bcd1), .neg(ng[1]), .overflow(of[1]), .busy(bz[1]));
    bin2bcd_seq #(.BIN_W(12), .DIGITS(4), .SIGNED(1)) u_d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .bin(bin),
        .out_valid(ov[2]), .out_ready(ordy[2]), .bcd(bcd2), .neg(ng[2]), .overflow(of[2]), .busy(bz[2]));

    typedef struct {
        int          d;
        int          id;
        int          acc;
        logic [15:0] bcd;
        logic        neg;
        logic        ovf;
    } exp_t;

    exp_t       q[$];
    int         tests = 0, fails = 0, cyc = 0, next_id = 0, lat_id = -1;
    logic [2:0] want_rdy = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // reference: decimal digits of the magnitude by plain division
    function automatic exp_t model(input int d, input logic [11:0] v);
        exp_t e;
        int   m;
        int   nd;
        nd = (d == 1) ? 3 : 4;
        e.d = d;
        e.id = 0;
        e.acc = 0;
        e.neg = (d == 2) && v[11];
        m = e.neg ? 4096 - int'(v) : int'(v);
        e.ovf = m >= ((nd == 3) ? 1000 : 10000);
        e.bcd = '0;
        for (int i = 0; i < nd; i++) begin
            e.bcd[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return e;
    endfunction

    function automatic logic [15:0] bcd_of(input int d);
        return (d == 0) ? bcd0 : (d == 1) ? {4'h0, bcd1} : bcd2;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (want_rdy[d]) begin
                check("in_ready_after_release", {30'd0, ir[d], ov[d]}, 32'b10);
                want_rdy[d] = 1'b0;
            end
            if (ov[d]) begin
                if (q.size() == 0 || q[0].d != d) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: dut%0d bcd=%h with nothing expected", d, bcd_of(d));
                end else begin
                    if (q[0].id != lat_id) begin
                        check("latency", cyc - q[0].acc, 12);
                        lat_id = q[0].id;
                    end
                    check("bcd", bcd_of(d), q[0].bcd);
                    check("neg", ng[d], q[0].neg);
                    check("overflow", of[d], q[0].ovf);
                    check("in_ready_low_done", ir[d], 0);
                    check("busy_done", bz[d], 1);
                    if (ordy[d]) begin
                        void'(q.pop_front());
                        want_rdy[d] = 1'b1;
                    end
                end
            end
        end
    end

    // called at posedge+#1; returns at posedge+#1 after the accept edge
    task automatic send(input int d, input logic [11:0] v, input bit expect_out);
        bit   acc = 0;
        int   n = 0;
        exp_t e;
        bin = v;
        iv[d] = 1'b1;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = ir[d];
            @(posedge clk);
            #1;
            n++;
        end
        iv[d] = 1'b0;
        if (!acc) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: dut%0d never accepted %h", d, v);
        end else if (expect_out) begin
            e = model(d, v);
            e.acc = cyc;
            e.id = next_id++;
            q.push_back(e);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q.size() != 0 || bz != 3'b000) && n < 300) begin
            for (int d = 0; d < 3; d++)
                if (bz[d]) check("in_ready_low_busy", ir[d], 0);
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 300) begin
            tests++;
            fails++;
            $display("FAIL idle_timeout: queue=%0d busy=%b", q.size(), bz);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", ov, 0);
        check("reset_busy", bz, 0);
        check("reset_bcd0", bcd0, 0);
        check("reset_neg", ng, 0);
        check("reset_overflow", of, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_after_reset", ir, 3'b111);

        send(0, 12'd4095, 1);
        wait_idle();

        send(0, 12'd0, 1);
        send(0, 12'd1, 1);
        wait_idle();

        ordy[0] = 1'b0;
        send(0, 12'd999, 1);
        n = 0;
        while (!ov[0] && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("backpressure_valid_seen", ov[0], 1);
        for (int i = 0; i < 20; i++) begin
            iv[0] = 1'($urandom);
            bin = 12'($urandom);
            @(posedge clk);
            #1;
        end
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        wait_idle();

        send(1, 12'd1234, 1);
        send(1, 12'd999, 1);
        send(1, 12'd1000, 1);
        wait_idle();

        send(2, 12'h800, 1);
        send(2, 12'hFFF, 1);
        send(2, 12'h7FF, 1);
        send(2, 12'h000, 1);
        wait_idle();

        send(0, 12'd4095, 0);
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midreset_out_valid", ov[0], 0);
        check("midreset_busy", bz[0], 0);
        check("midreset_bcd", bcd0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(0, 12'd42, 1);
        wait_idle();

        for (int i = 0; i < 60; i++) begin
            send(int'($urandom_range(2, 0)), 12'($urandom), 1);
            wait_idle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
